// File: rtl/wall_datapath.sv
// Scrolling wall (pipe) for the flappy-bird game: per accepted frame it erases the
// wall, moves it left (wrapping with a new random gap) and redraws it, one pixel per clock.
module wall_datapath #(
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter int         WALL_W      = 8,
    parameter int         GAP_H       = 40,
    parameter int         STEP        = 1,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter logic [2:0] WALL_COLOUR = 3'b010,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       run,
    input  logic       halt,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [7:0] wall_x,
    output logic [6:0] gap_y,
    output logic       busy,
    output logic       frame_done,
    output logic       score_pulse
);
    localparam int CW = (WALL_W > 1) ? $clog2(WALL_W) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ERASE = 3'd1;
    localparam logic [2:0] MOVE  = 3'd2;
    localparam logic [2:0] DRAW  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [7:0]    WALL_HOME = 8'(SCREEN_W - WALL_W);
    localparam logic [7:0]    STEP_W    = 8'(STEP);
    localparam logic [7:0]    GAP_H_W   = 8'(GAP_H);
    localparam logic [6:0]    GAP_RESET = 7'd40;
    localparam logic [CW-1:0] COL_LAST  = CW'(WALL_W - 1);
    localparam logic [6:0]    ROW_LAST  = 7'(SCREEN_H - 1);

    logic [2:0]    state, state_n;
    logic [CW-1:0] col, col_n;
    logic [6:0]    row, row_n;
    logic [7:0]    wall_x_n;
    logic [6:0]    gap_y_n;
    logic [7:0]    lfsr;
    logic          wrap;
    logic          in_gap_n;

    assign wrap = wall_x < STEP_W;

    // Gap test is done on the next-cycle row/gap so plot can be registered with x/y.
    assign in_gap_n = ({1'b0, row_n} >= {1'b0, gap_y_n}) &&
                      ({1'b0, row_n} <  ({1'b0, gap_y_n} + GAP_H_W));

    always_comb begin
        state_n  = state;
        col_n    = col;
        row_n    = row;
        wall_x_n = wall_x;
        gap_y_n  = gap_y;
        case (state)
            IDLE: begin
                if (frame_tick && run && !halt) begin
                    state_n = ERASE;
                    col_n   = '0;
                    row_n   = '0;
                end
            end
            ERASE, DRAW: begin
                if (col == COL_LAST) begin
                    col_n = '0;
                    if (row == ROW_LAST) begin
                        row_n   = '0;
                        state_n = (state == ERASE) ? MOVE : DONE;
                    end else begin
                        row_n = row + 7'd1;
                    end
                end else begin
                    col_n = col + CW'(1);
                end
            end
            MOVE: begin
                state_n = DRAW;
                col_n   = '0;
                row_n   = '0;
                if (wrap) begin
                    wall_x_n = WALL_HOME;
                    gap_y_n  = 7'd8 + {1'b0, lfsr[5:0]};
                end else begin
                    wall_x_n = wall_x - STEP_W;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            wall_x      <= WALL_HOME;
            gap_y       <= GAP_RESET;
            lfsr        <= LFSR_SEED;
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            plot        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            score_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            col         <= col_n;
            row         <= row_n;
            wall_x      <= wall_x_n;
            gap_y       <= gap_y_n;
            // x^8+x^6+x^5+x^4+1, free-running so the gap depends on game timing.
            lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            x           <= wall_x_n + 8'(col_n);
            y           <= row_n;
            colour      <= (state_n == DRAW) ? WALL_COLOUR : BG_COLOUR;
            plot        <= ((state_n == ERASE) || (state_n == DRAW)) && !in_gap_n;
            busy        <= (state_n != IDLE);
            frame_done  <= (state_n == DONE);
            score_pulse <= (state_n == MOVE) && wrap;
        end
    end
endmodule

// File: tb/tb_wall_datapath.sv
// Directed bench for wall_datapath: full-pass pixel checks on the default screen, plus a
// narrow-screen instance so the wrap/score path is reached in a short run.
module tb_wall_datapath;
    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick, run, halt;
    logic [7:0] x, wall_x;
    logic [6:0] y, gap_y;
    logic [2:0] colour;
    logic       plot, busy, frame_done, score_pulse;

    logic       w_tick, w_run, w_halt;
    logic [7:0] w_x, w_wall_x;
    logic [6:0] w_y, w_gap_y;
    logic [2:0] w_colour;
    logic       w_plot, w_busy, w_frame_done, w_score;

    logic [7:0] lfsr_m;
    logic [7:0] exp_wx;
    logic [6:0] exp_gap;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_erase, n_draw;

    always #5 clk = ~clk;

    wall_datapath dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .halt(halt),
        .x(x), .y(y), .colour(colour), .plot(plot), .wall_x(wall_x), .gap_y(gap_y),
        .busy(busy), .frame_done(frame_done), .score_pulse(score_pulse)
    );

    wall_datapath #(.SCREEN_W(24)) dut_w (
        .clk(clk), .reset(reset), .frame_tick(w_tick), .run(w_run), .halt(w_halt),
        .x(w_x), .y(w_y), .colour(w_colour), .plot(w_plot), .wall_x(w_wall_x), .gap_y(w_gap_y),
        .busy(w_busy), .frame_done(w_frame_done), .score_pulse(w_score)
    );

    // Reference LFSR, x^8+x^6+x^5+x^4+1 from seed A5.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_m <= 8'hA5;
        else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One accepted frame on the main instance; every cycle T+1..T+1923 is compared.
    task automatic run_frame(input int halt_at, input int tick_at, output int errs);
        logic [7:0] wx0, wx1, ex;
        logic [6:0] g0, g1, gg;
        logic [2:0] ec;
        logic       wr, ep;
        int         idx, c, r;
        errs = 0; n_erase = 0; n_draw = 0;
        wx0 = exp_wx; g0 = exp_gap; wr = (wx0 == 8'd0);
        wx1 = wr ? 8'd152 : wx0 - 8'd1;
        g1  = g0;
        @(negedge clk);
        frame_tick = 1'b1;
        for (int k = 1; k <= 1923; k++) begin
            @(negedge clk);
            if (k == 1) frame_tick = 1'b0;
            if (busy !== (k <= 1922)) errs++;
            if (frame_done !== (k == 1922)) errs++;
            if (score_pulse !== (wr && k == 961)) errs++;
            if (k == 961 && wr) g1 = 7'd8 + {1'b0, lfsr_m[5:0]};
            if (k <= 960 || (k >= 962 && k <= 1921)) begin
                idx = (k <= 960) ? k - 1 : k - 962;
                c   = idx % 8;
                r   = idx / 8;
                gg  = (k <= 960) ? g0 : g1;
                ex  = ((k <= 960) ? wx0 : wx1) + 8'(c);
                ep  = !(r >= int'(gg) && r < int'(gg) + 40);
                ec  = (k <= 960) ? 3'b000 : 3'b010;
                if (x !== ex || y !== 7'(r) || colour !== ec || plot !== ep) errs++;
                if (plot === 1'b1) begin
                    if (k <= 960) n_erase++;
                    else          n_draw++;
                end
            end else if (plot !== 1'b0) begin
                errs++;
            end
            if (k == halt_at) halt = 1'b1;
            if (k == tick_at) frame_tick = 1'b1;
            if (k == tick_at + 1) frame_tick = 1'b0;
        end
        exp_wx = wx1; exp_gap = g1;
    endtask

    // Ticks applied while the block must ignore them; counts any activity.
    task automatic idle_ticks(output int bad);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || plot !== 1'b0) bad++;
            frame_tick = (i % 3 == 0);
        end
        frame_tick = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (busy !== 1'b0 || plot !== 1'b0) bad++;
        end
    endtask

    initial begin
        int errs, bad, sc, scerr;
        logic [6:0] gsave;
        reset = 1'b1; frame_tick = 1'b0; run = 1'b0; halt = 1'b0;
        w_tick = 1'b0; w_run = 1'b1; w_halt = 1'b0;
        gsave = '0;
        repeat (2) @(negedge clk);

        chk("rst_wall_x", wall_x, 152);
        chk("rst_gap_y", gap_y, 40);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_score", score_pulse, 0);
        reset = 1'b0;
        exp_wx = 8'd152; exp_gap = 7'd40;

        // First frame: erase 152..159, draw 151..158, gap rows 40..79 unplotted.
        run = 1'b1;
        run_frame(0, 0, errs);
        chk("frame1_cycles", errs, 0);
        chk("frame1_erase_plots", n_erase, 640);
        chk("frame1_draw_plots", n_draw, 640);
        chk("frame1_wall_x", wall_x, 151);
        chk("frame1_gap_y", gap_y, 40);

        run = 1'b0;
        idle_ticks(bad);
        chk("run0_ignored", bad, 0);
        chk("run0_wall_x", wall_x, 151);
        run = 1'b1; halt = 1'b1;
        idle_ticks(bad);
        chk("halt_ignored", bad, 0);
        chk("halt_wall_x", wall_x, 151);
        halt = 1'b0;

        // Tick mid-pass is dropped; pass length and following idle unchanged.
        run_frame(0, 500, errs);
        chk("drop_tick_cycles", errs, 0);
        chk("drop_tick_wall_x", wall_x, 150);

        // Halt mid-pass: pass still completes, then ticks are ignored.
        run_frame(500, 0, errs);
        chk("halt_mid_cycles", errs, 0);
        chk("halt_mid_wall_x", wall_x, 149);
        idle_ticks(bad);
        chk("halt_after_ignored", bad, 0);
        chk("halt_after_wall_x", wall_x, 149);
        halt = 1'b0;

        // Async reset during DRAW (T+1000, a plotted row).
        @(negedge clk);
        frame_tick = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (k == 1) frame_tick = 1'b0;
        end
        chk("pre_rst_plot", plot, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_plot", plot, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        chk("mid_rst_wall_x", wall_x, 152);
        chk("mid_rst_x", x, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_wx = 8'd152; exp_gap = 7'd40;

        // Narrow screen: wall_x 16 -> 0 in 16 frames, 17th frame wraps.
        sc = 0; scerr = 0;
        for (int f = 0; f <= 16; f++) begin
            @(negedge clk);
            w_tick = 1'b1;
            for (int k = 1; k <= 1923; k++) begin
                @(negedge clk);
                if (k == 1) w_tick = 1'b0;
                if (w_score === 1'b1) begin
                    sc++;
                    if (k != 961 || f != 16) scerr++;
                end
                if (k == 961 && f == 16) gsave = 7'd8 + {1'b0, lfsr_m[5:0]};
            end
            if (f == 15) chk("wrap_reach_zero", w_wall_x, 0);
        end
        chk("wrap_wall_x", w_wall_x, 16);
        chk("wrap_gap_y", w_gap_y, gsave);
        chk("wrap_gap_range", (w_gap_y >= 7'd8 && w_gap_y <= 7'd71), 1);
        chk("wrap_score_count", sc, 1);
        chk("wrap_score_timing", scerr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
